// File: rtl/uart_rx_cfg.sv
// Parameterised UART receiver: 2-flop synchronizer, mid-bit 2-of-3 majority sampling,
// optional parity, and a single-entry holding register with valid/ready handshake.
module uart_rx_cfg #(
  parameter int WCNT      = 200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int          H        = WCNT / 2;
  localparam logic [11:0] CNT_LAST = 12'(WCNT - 1);
  localparam logic [11:0] CNT_S0   = 12'(H - 1);
  localparam logic [11:0] CNT_S1   = 12'(H);
  localparam logic [11:0] CNT_S2   = 12'(H + 1);
  localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);
  localparam logic        ODD      = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state_q, state_d;
  logic                 meta_q, rxs_q;
  logic [11:0]          cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]           smp_q, smp_d;
  logic                 par_bad_q, par_bad_d;
  logic                 armed_q, armed_d;
  logic                 maj, frame_done, stop_bad;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;
  logic                 accept;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= i_rxd;
      rxs_q  <= meta_q;
    end
  end

  assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);

  // armed_q blocks a held-low line (break) from re-triggering until it has idled high.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CNT_LAST) ? 12'd0 : cnt_q + 12'd1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    smp_d      = smp_q;
    par_bad_d  = par_bad_q;
    armed_d    = armed_q;
    frame_done = 1'b0;
    stop_bad   = 1'b0;
    if (state_q != S_IDLE) begin
      if (cnt_q == CNT_S0) smp_d[0] = rxs_q;
      if (cnt_q == CNT_S1) smp_d[1] = rxs_q;
    end
    case (state_q)
      S_IDLE: begin
        cnt_d = 12'd0;
        if (rxs_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d   = S_START;
          armed_d   = 1'b0;
          bit_d     = 3'd0;
          par_bad_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_S2 && maj) begin
          state_d = S_IDLE;
          cnt_d   = 12'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_S2) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (cnt_q == CNT_LAST) begin
          if (bit_q == BIT_LAST) state_d = (PARITY != 0) ? S_PAR : S_STOP;
          else                   bit_d   = bit_q + 3'd1;
        end
      end
      S_PAR: begin
        if (cnt_q == CNT_S2) par_bad_d = (^shreg_q) ^ ODD ^ maj;
        if (cnt_q == CNT_LAST) state_d = S_STOP;
      end
      S_STOP: begin
        if (cnt_q == CNT_S2) begin
          frame_done = 1'b1;
          stop_bad   = ~maj;
          state_d    = S_IDLE;
          cnt_d      = 12'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 12'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 12'd0;
      bit_q     <= 3'd0;
      shreg_q   <= '0;
      smp_q     <= 2'b11;
      par_bad_q <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      smp_q     <= smp_d;
      par_bad_q <= par_bad_d;
      armed_q   <= armed_d;
    end
  end

  // A frame arriving while the register is full and not being consumed is dropped.
  always_comb begin
    accept  = valid_q & i_ready;
    valid_d = valid_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;
    if (frame_done) begin
      if (!valid_q || i_ready) begin
        valid_d = 1'b1;
        data_d  = shreg_q;
        ferr_d  = stop_bad;
        perr_d  = par_bad_q;
        if (accept) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perr_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: two instances (no parity, even parity) fed by
// directed frames; a negedge monitor pops expected frames on each handshake.
module tb_uart_rx_cfg;
  localparam int W  = 16;
  localparam int H  = W / 2;
  localparam int DB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] rxd, rdy;
  logic [7:0] d0, d1;
  logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, bz0, bz1;

  uart_rx_cfg #(.WCNT(W), .DATA_BITS(DB), .PARITY(0)) u0 (
    .clk(clk), .i_rst_n(rst_n), .i_rxd(rxd[0]), .o_data(d0), .o_valid(v0),
    .i_ready(rdy[0]), .o_frame_err(fe0), .o_parity_err(pe0), .o_overrun(ov0), .o_busy(bz0));

  uart_rx_cfg #(.WCNT(W), .DATA_BITS(DB), .PARITY(1)) u1 (
    .clk(clk), .i_rst_n(rst_n), .i_rxd(rxd[1]), .o_data(d1), .o_valid(v1),
    .i_ready(rdy[1]), .o_frame_err(fe1), .o_parity_err(pe1), .o_overrun(ov1), .o_busy(bz1));

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // o_valid rise, counted from the falling-edge capture into the synchronizer.
  function automatic int lat(int p);
    return 2 + (1 + DB + p) * W + H + 2;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(int k, logic [7:0] d, logic fe, logic pe, int c);
    exp_t e;
    e.data = d; e.fe = fe; e.pe = pe; e.cyc = c;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon(int k, logic [7:0] d, logic fe, logic pe);
    exp_t e;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      n_cmp++;
      n_err++;
      $display("FAIL dut%0d unexpected_frame: got data %0h, expected no frame", k, d);
      return;
    end
    e = (k == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("dut%0d data", k), int'(d), int'(e.data));
    chk($sformatf("dut%0d frame_err", k), int'(fe), int'(e.fe));
    chk($sformatf("dut%0d parity_err", k), int'(pe), int'(e.pe));
    if (e.cyc >= 0) chk($sformatf("dut%0d latency_cycle", k), cyc, e.cyc);
  endtask

  always @(negedge clk) if (rst_n === 1'b1 && v0 === 1'b1 && rdy[0] === 1'b1) mon(0, d0, fe0, pe0);
  always @(negedge clk) if (rst_n === 1'b1 && v1 === 1'b1 && rdy[1] === 1'b1) mon(1, d1, fe1, pe1);

  // One bit period; an optional one-cycle inverted glitch lands on the centre sample.
  task automatic drive_bit(int k, logic v, bit glitch);
    for (int c = 0; c < W; c++) begin
      rxd[k] = (glitch && c == H + 1) ? ~v : v;
      @(posedge clk); #1;
    end
  endtask

  // par < 0: no parity bit; otherwise its LSB is the transmitted parity bit (bench assumes even).
  task automatic send(int k, logic [7:0] d, int par, logic stop, int gbit,
                      bit expect_it, bit chk_lat, int brk, output bit busy_in_brk);
    logic pe;
    int   p;
    busy_in_brk = 1'b0;
    @(posedge clk); #1;
    p  = (par >= 0) ? 1 : 0;
    pe = (par >= 0) ? ((^d) ^ par[0]) : 1'b0;
    if (expect_it) push(k, d, ~stop, pe, chk_lat ? cyc + lat(p) + 1 : -1);
    drive_bit(k, 1'b0, 1'b0);
    for (int i = 0; i < DB; i++) drive_bit(k, d[i], gbit == i);
    if (par >= 0) drive_bit(k, par[0], 1'b0);
    drive_bit(k, stop, 1'b0);
    for (int i = 0; i < brk; i++) begin
      if ((k == 0 ? bz0 : bz1) === 1'b1) busy_in_brk = 1'b1;
      @(posedge clk); #1;
    end
    rxd[k] = 1'b1;
    repeat (2 * W) @(posedge clk);
    #1;
  endtask

  bit dummy, saw_busy, saw_valid;

  initial begin
    rst_n = 1'b0;
    rxd   = 2'b11;
    rdy   = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("reset data", int'(d0), 0);
    chk("reset valid", int'(v0), 0);
    chk("reset frame_err", int'(fe0), 0);
    chk("reset parity_err", int'(pe0), 0);
    chk("reset overrun", int'(ov0), 0);
    chk("reset busy", int'(bz0), 0);
    chk("reset valid dut1", int'(v1), 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    send(0, 8'h55, -1, 1'b1, -1, 1'b1, 1'b1, 0, dummy);
    send(0, 8'h0F, -1, 1'b0, -1, 1'b1, 1'b1, 0, dummy);
    send(0, 8'h3C, -1, 1'b1, -1, 1'b1, 1'b1, 0, dummy);
    send(0, 8'h00, -1, 1'b0, -1, 1'b1, 1'b0, 3 * W, saw_busy);
    chk("break no retrigger", int'(saw_busy), 0);

    saw_busy  = 1'b0;
    saw_valid = 1'b0;
    @(posedge clk); #1;
    rxd[0] = 1'b0;
    for (int i = 0; i < 4 + 3 * W; i++) begin
      if (i == 4) rxd[0] = 1'b1;
      @(posedge clk); #1;
      if (bz0) saw_busy = 1'b1;
      if (v0) saw_valid = 1'b1;
    end
    chk("short pulse busy seen", int'(saw_busy), 1);
    chk("short pulse busy cleared", int'(bz0), 0);
    chk("short pulse no valid", int'(saw_valid), 0);

    send(0, 8'hA5, -1, 1'b1, 1, 1'b1, 1'b1, 0, dummy);

    rdy[0] = 1'b0;
    send(0, 8'h11, -1, 1'b1, -1, 1'b1, 1'b0, 0, dummy);
    chk("held valid", int'(v0), 1);
    chk("overrun before second", int'(ov0), 0);
    send(0, 8'h22, -1, 1'b1, -1, 1'b0, 1'b0, 0, dummy);
    chk("overrun set", int'(ov0), 1);
    chk("held data stable", int'(d0), 'h11);
    chk("held valid after drop", int'(v0), 1);
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    chk("valid cleared by handshake", int'(v0), 0);
    chk("overrun cleared by handshake", int'(ov0), 0);

    @(posedge clk); #1;
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, 1'b0);
    rxd[0] = 1'b1;
    repeat (H) @(posedge clk);
    #1;
    chk("busy mid frame", int'(bz0), 1);
    rst_n = 1'b0;
    #1;
    chk("mid reset data", int'(d0), 0);
    chk("mid reset valid", int'(v0), 0);
    chk("mid reset frame_err", int'(fe0), 0);
    chk("mid reset overrun", int'(ov0), 0);
    chk("mid reset busy", int'(bz0), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2 * W) @(posedge clk);
    #1;
    send(0, 8'h7E, -1, 1'b1, -1, 1'b1, 1'b1, 0, dummy);

    send(1, 8'hA3, 1, 1'b1, -1, 1'b1, 1'b1, 0, dummy);
    send(1, 8'hA3, 0, 1'b1, -1, 1'b1, 1'b1, 0, dummy);
    chk("dut1 overrun", int'(ov1), 0);

    for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    #1;
    chk("dut0 frames outstanding", q0.size(), 0);
    chk("dut1 frames outstanding", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL provide parameter WCNT, default 200: clk cycles per bit (f/b); legal range 8..4095.
REQ-002 SHALL provide parameter DATA_BITS, default 8: data bits per frame; legal range 5..8.
REQ-003 SHALL provide parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-004 SHALL provide port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL provide port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL provide port i_rxd  input  1  asynchronous serial line; idle high.
REQ-007 SHALL provide port o_data  output  DATA_BITS  received data, LSB = first data bit.
REQ-008 SHALL provide port o_valid  output  1  holding register holds an unconsumed frame.
REQ-009 SHALL provide port i_ready  input  1  consumer accepts the frame when o_valid & i_ready.
REQ-010 SHALL provide port o_frame_err  output  1  stop bit of the held frame sampled 0.
REQ-011 SHALL provide port o_parity_err  output  1  parity mismatch in the held frame; always 0 when PARITY=0.
REQ-012 SHALL provide port o_overrun  output  1  sticky: a frame completed and was discarded while the register was full.
REQ-013 SHALL provide port o_busy  output  1  receiver FSM not in IDLE.

Function
REQ-014 SHALL pass i_rxd through a 2-flop synchronizer (reset value 1); "rxs" below means the synchronizer output.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PAR, STOP; PAR SHALL be skipped when PARITY=0.
REQ-016 SHALL use a bit-phase counter cnt (0..WCNT-1) and define H = WCNT/2 (integer division).
REQ-017 IDLE: on rxs = 0, SHALL go to START with cnt = 0; that cycle is phase 0 of the start bit.
REQ-018 In every non-IDLE state, SHALL sample rxs at cnt = H-1, H and H+1, and SHALL take the 2-of-3 majority as the bit value at cnt = H+1.
REQ-019 START: majority 1 SHALL be treated as a glitch and return the FSM to IDLE at the cycle after cnt = H+1; majority 0 SHALL continue.
REQ-020 SHALL increment cnt every cycle, wrap it from WCNT-1 to 0, and advance the state or bit index on each wrap.
REQ-021 DATA: SHALL shift in DATA_BITS bits, LSB first, then go to PAR or STOP.
REQ-022 PAR: SHALL compute expected parity as XOR of the data bits (even), inverted for odd, and SHALL record the mismatch.
REQ-023 STOP: SHALL complete the frame at cnt = H+1 and return to IDLE the next cycle, without waiting for the full stop period.
REQ-024 On completion with o_valid = 0, or with o_valid & i_ready in the same cycle, SHALL load o_data, o_frame_err and o_parity_err and set o_valid = 1 on the next edge.
REQ-025 On completion with o_valid = 1 and i_ready = 0, SHALL discard the new frame, keep the held frame unchanged, and set o_overrun = 1.
REQ-026 o_valid & i_ready without completion SHALL clear o_valid, o_frame_err and o_parity_err on the next edge.
REQ-027 o_overrun SHALL clear on the next accepted handshake, unless a discard occurs in the same cycle.
REQ-028 o_data and the error flags SHALL stay stable while o_valid = 1 and no handshake occurs.
REQ-029 Latency SHALL be: o_valid rises 2 (synchronizer) + (1+DATA_BITS+P)*WCNT + H+2 cycles after the i_rxd falling edge, where P = 1 if PARITY != 0, else 0.
REQ-030 A frame error SHALL still deliver the frame; a line held low (break) SHALL NOT re-trigger until rxs has returned to 1 in IDLE.

Reset
REQ-031 While i_rst_n = 0: o_data = 0, o_valid = 0, o_frame_err = 0, o_parity_err = 0, o_overrun = 0, o_busy = 0; FSM = IDLE, cnt = 0, synchronizer = 1.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; after release, the first valid start bit SHALL begin a new frame normally.

Verification (WCNT=16, DATA_BITS=8 unless stated)
REQ-033 PARITY=0; send 0x55 with stop = 1, i_ready = 1 -> one o_valid pulse, o_data = 0x55, all error flags 0, at the REQ-029 cycle.
REQ-034 PARITY=1; send 0xA3 with parity bit 1 (wrong) -> o_data = 0xA3, o_parity_err = 1; resend with parity bit 0 -> o_parity_err = 0.
REQ-035 Send 0x0F with stop bit 0 -> o_data = 0x0F, o_frame_err = 1; the next good 0x3C -> o_frame_err = 0.
REQ-036 Pulse i_rxd low for 4 cycles only -> o_busy pulses, o_valid never asserts; also one-cycle high glitch mid-bit -> majority gives the correct bit.
REQ-037 i_ready = 0; send 0x11 then 0x22 -> o_data stays 0x11, o_overrun = 1; raise i_ready -> handshake, o_valid = 0, o_overrun = 0.
REQ-038 Assert i_rst_n = 0 during the 4th data bit -> all outputs 0; release and send 0x7E -> o_data = 0x7E.
